// File: rtl/pulse_detect_pkg.sv
// Shared helpers for the pulse width detector: run-length width and saturating increment.
package pulse_detect_pkg;

  function automatic int calc_cw(input int max_w);
    return $clog2(max_w + 2);
  endfunction

  // Holds at limit instead of wrapping; callers truncate to their own width.
  function automatic int unsigned sat_inc(input int unsigned value, input int unsigned limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/pulse_width_channel.sv
// One channel of the pulse width detector: edge flags, run-length counter, accepted-pulse counter.
// Optional PULSE_WIDTH_DETECTOR_SYNC_EN inserts a 2-flop synchroniser in front of all logic.
module pulse_width_channel
  import pulse_detect_pkg::*;
#(
  parameter int MIN_W   = 1,
  parameter int MAX_W   = 4,
  parameter int COUNT_W = 8,
  parameter int CW      = calc_cw(MAX_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a,
  input  logic               clr,
  output logic               rise,
  output logic               fall,
  output logic               detected,
  output logic               too_long,
  output logic [CW-1:0]      len,
  output logic [COUNT_W-1:0] count
);

  localparam logic [CW-1:0] MIN_C = CW'(MIN_W);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_W);
  localparam int unsigned   SAT_LEN = MAX_W + 1;
  localparam int unsigned   COUNT_MAX = (COUNT_W >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << COUNT_W) - 32'd1);

  logic               a_s;
  logic               a_r;
  logic [CW-1:0]      cnt;
  logic [COUNT_W-1:0] count_q;
  logic               rise_i;
  logic               fall_i;
  logic               det_i;

`ifdef PULSE_WIDTH_DETECTOR_SYNC_EN
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= a;
      sync_2 <= sync_1;
    end
  end

  assign a_s = sync_2;
`else
  assign a_s = a;
`endif

  assign rise_i = a_s & ~a_r;
  assign fall_i = ~a_s & a_r;
  assign det_i  = fall_i & (cnt >= MIN_C) & (cnt <= MAX_C);

  // cnt saturates at MAX_W+1 so an over-long run is still reported as too long at its fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= 1'b0;
      cnt <= '0;
    end else begin
      a_r <= a_s;
      cnt <= a_s ? CW'(sat_inc(32'(cnt), SAT_LEN)) : '0;
    end
  end

  // A clear coinciding with a detection keeps that detection, so the count restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= det_i ? COUNT_W'(1) : '0;
    end else if (det_i) begin
      count_q <= COUNT_W'(sat_inc(32'(count_q), COUNT_MAX));
    end
  end

  assign rise     = rise_i & ~rst;
  assign fall     = fall_i & ~rst;
  assign detected = det_i & ~rst;
  assign too_long = a_s & (cnt == MAX_C) & ~rst;
  assign len      = (fall_i & ~rst) ? cnt : '0;
  assign count    = rst ? '0 : count_q;

endmodule

// File: rtl/pulse_width_detector.sv
// Multi-channel pulse width detector; one pulse_width_channel per input line, flat len/count buses.
// Optional PULSE_WIDTH_DETECTOR_SYNC_EN adds a 2-cycle input synchroniser on every channel.
module pulse_width_detector
  import pulse_detect_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int MIN_W     = 1,
  parameter int MAX_W     = 4,
  parameter int COUNT_W   = 8,
  localparam int CW       = calc_cw(MAX_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           a,
  input  logic                          clr,
  output logic [CHANNELS-1:0]           rise,
  output logic [CHANNELS-1:0]           fall,
  output logic [CHANNELS-1:0]           detected,
  output logic [CHANNELS-1:0]           too_long,
  output logic [CHANNELS*CW-1:0]        len,
  output logic [CHANNELS*COUNT_W-1:0]   count
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pulse_width_channel #(
      .MIN_W   (MIN_W),
      .MAX_W   (MAX_W),
      .COUNT_W (COUNT_W),
      .CW      (CW)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .a        (a[c]),
      .clr      (clr),
      .rise     (rise[c]),
      .fall     (fall[c]),
      .detected (detected[c]),
      .too_long (too_long[c]),
      .len      (len[c*CW +: CW]),
      .count    (count[c*COUNT_W +: COUNT_W])
    );
  end

endmodule

// File: tb/tb_pulse_width_detector.sv
// Directed bench for pulse_width_detector: default instance plus a MIN_W=2/MAX_W=3 instance.
module tb_pulse_width_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [3:0]  a;
  logic [3:0]  a2;

  logic [3:0]  rise, fall, detected, too_long;
  logic [11:0] len;
  logic [31:0] count;

  logic [3:0]  rise2, fall2, detected2, too_long2;
  logic [11:0] len2;
  logic [31:0] count2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int tl_hits;
  logic [3:0] det_or;

  always #5 clk = ~clk;

  pulse_width_detector #(.CHANNELS(4), .MIN_W(1), .MAX_W(4), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .clr(clr),
    .rise(rise), .fall(fall), .detected(detected), .too_long(too_long),
    .len(len), .count(count)
  );

  pulse_width_detector #(.CHANNELS(4), .MIN_W(2), .MAX_W(3), .COUNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .a(a2), .clr(clr),
    .rise(rise2), .fall(fall2), .detected(detected2), .too_long(too_long2),
    .len(len2), .count(count2)
  );

  // Drive one sample on the falling edge; outputs are then observed 1 ns later.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] a2v,
                               input logic c, input logic r);
    @(negedge clk);
    a   = av;
    a2  = a2v;
    clr = c;
    rst = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a = '0; a2 = '0; clr = 1'b0; rst = 1'b1;

    // Reset with inputs high: every output held low
    applyStimulus(4'hF, 4'hF, 1'b0, 1'b1);
    applyStimulus(4'hF, 4'hF, 1'b0, 1'b1);
    checkOutput("rst_rise", 32'(rise), 32'h0);
    checkOutput("rst_too_long", 32'(too_long), 32'h0);
    checkOutput("rst_len", 32'(len), 32'h0);
    checkOutput("rst_count", count, 32'h0);
    checkOutput("rst_rise2", 32'(rise2), 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("post_rst_fall", 32'(fall), 32'h0);

    // Single 1-cycle pulse on channel 0
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    checkOutput("single_rise", 32'(rise), 32'h1);
    checkOutput("single_len_high", 32'(len), 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("single_fall", 32'(fall), 32'h1);
    checkOutput("single_det", 32'(detected), 32'h1);
    checkOutput("single_len", 32'(len), 32'h1);
    checkOutput("single_count_pre", count, 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("single_count", count, 32'h1);

    // 4-cycle run: accepted, len 4
    for (int i = 1; i <= 4; i++) applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    checkOutput("run4_too_long", 32'(too_long), 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("run4_det", 32'(detected), 32'h1);
    checkOutput("run4_len", 32'(len), 32'h4);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("run4_count", count, 32'h2);

    // 5-cycle run: too_long on 5th high cycle, rejected with len 5
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
      checkOutput($sformatf("run5_too_long_%0d", i), 32'(too_long), (i == 5) ? 32'h1 : 32'h0);
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("run5_fall", 32'(fall), 32'h1);
    checkOutput("run5_len", 32'(len), 32'h5);
    checkOutput("run5_det", 32'(detected), 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("run5_count", count, 32'h2);

    // 9-cycle run: too_long exactly once, len saturates at 5
    tl_hits = 0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
      tl_hits += int'(too_long[0]);
    end
    checkOutput("run9_too_long_once", 32'(tl_hits), 32'h1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("run9_len", 32'(len), 32'h5);
    checkOutput("run9_det", 32'(detected), 32'h0);

    // Counter: clear, three pulses, clear coincident with 4th detection
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("clr_count", count, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("three_pulses_count", count, 32'h3);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("clr_det_same_cycle", 32'(detected), 32'h1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("clr_with_det_count", count, 32'h1);

    // Saturation of the 8-bit counter
    for (int i = 0; i < 253; i++) begin
      applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("count_254", count, 32'd254);
    for (int i = 0; i < 47; i++) begin
      applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("count_sat_255", count, 32'd255);

    // Reset in the middle of a run: run discarded, restarts as a fresh rise
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b1);
    checkOutput("midrst_count_forced", count, 32'h0);
    checkOutput("midrst_rise", 32'(rise), 32'h0);
    checkOutput("midrst_det", 32'(detected), 32'h0);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    checkOutput("midrst_post_rise", 32'(rise), 32'h1);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("midrst_len", 32'(len), 32'h3);
    checkOutput("midrst_det_after", 32'(detected), 32'h1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("midrst_count", count, 32'h1);

    // Independence: runs of 1, 4, 5 and long-high on channels 0..3
    det_or = '0;
    applyStimulus(4'b1111, 4'h0, 1'b0, 1'b0);
    checkOutput("ind_rise", 32'(rise), 32'hF);
    det_or |= detected;
    applyStimulus(4'b1110, 4'h0, 1'b0, 1'b0);
    checkOutput("ind_k2_det", 32'(detected), 32'h1);
    checkOutput("ind_k2_len", 32'(len), 32'h001);
    det_or |= detected;
    applyStimulus(4'b1110, 4'h0, 1'b0, 1'b0);
    det_or |= detected;
    applyStimulus(4'b1110, 4'h0, 1'b0, 1'b0);
    checkOutput("ind_k4_too_long", 32'(too_long), 32'h0);
    det_or |= detected;
    applyStimulus(4'b1100, 4'h0, 1'b0, 1'b0);
    checkOutput("ind_k5_too_long", 32'(too_long), 32'hC);
    checkOutput("ind_k5_det", 32'(detected), 32'h2);
    checkOutput("ind_k5_len", 32'(len), 32'h020);
    det_or |= detected;
    applyStimulus(4'b1000, 4'h0, 1'b0, 1'b0);
    checkOutput("ind_k6_fall", 32'(fall), 32'h4);
    checkOutput("ind_k6_len", 32'(len), 32'h140);
    checkOutput("ind_k6_too_long", 32'(too_long), 32'h0);
    det_or |= detected;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1000, 4'h0, 1'b0, 1'b0);
      det_or |= detected;
    end
    checkOutput("ind_k9_too_long", 32'(too_long), 32'h0);
    applyStimulus(4'b0000, 4'h0, 1'b0, 1'b0);
    checkOutput("ind_ch3_fall", 32'(fall), 32'h8);
    checkOutput("ind_ch3_len", 32'(len), 32'hA00);
    det_or |= detected;
    checkOutput("ind_det_union", 32'(det_or), 32'h3);
    checkOutput("ind_count_bus", count, 32'h0000_0102);

    // Narrow window instance: MIN_W=2, MAX_W=3
    applyStimulus(4'h0, 4'h1, 1'b0, 1'b0);
    checkOutput("w23_rise", 32'(rise2), 32'h1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("w23_short_fall", 32'(fall2), 32'h1);
    checkOutput("w23_short_len", 32'(len2), 32'h1);
    checkOutput("w23_short_det", 32'(detected2), 32'h0);
    applyStimulus(4'h0, 4'h1, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h1, 1'b0, 1'b0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("w23_two_det", 32'(detected2), 32'h1);
    checkOutput("w23_two_len", 32'(len2), 32'h2);
    for (int i = 1; i <= 4; i++) applyStimulus(4'h0, 4'h1, 1'b0, 1'b0);
    checkOutput("w23_four_too_long", 32'(too_long2), 32'h1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("w23_four_len", 32'(len2), 32'h4);
    checkOutput("w23_four_det", 32'(detected2), 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("w23_count", count2, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pulse_width_detector.md
# pulse_width_detector

Multi-channel, parametrised generalisation of the single-cycle pulse detector. Per channel it flags rising and falling edges, measures the length of each high run, and reports runs whose length lies within [MIN_W, MAX_W]. It also flags runs that exceed MAX_W and keeps a saturating count of accepted pulses. It sits on sampled control or strobe lines in the sequential-basics area. With MIN_W = MAX_W = 1 it reproduces the 010 detector on every channel.

## Interface
- CHANNELS, 4, number of independent input channels
- MIN_W, 1, shortest accepted high-run length in cycles; constraint 1 <= MIN_W <= MAX_W
- MAX_W, 4, longest accepted high-run length in cycles
- COUNT_W, 8, width of each per-channel accepted-pulse counter
- Derived CW = $clog2(MAX_W+2), the run-length width
- clk  input  1  clock, all state on posedge
- rst  input  1  reset, synchronous, active-high
- a  input  CHANNELS  sampled input lines
- clr  input  1  synchronous clear of all pulse counters only
- rise  output  CHANNELS  a sampled high after a sampled low
- fall  output  CHANNELS  a sampled low after a sampled high
- detected  output  CHANNELS  run ended with length in [MIN_W, MAX_W]
- too_long  output  CHANNELS  run has just reached MAX_W+1
- len  output  CHANNELS*CW  channel c is at bits [c*CW +: CW]; run length, valid when fall[c], else 0
- count  output  CHANNELS*COUNT_W  channel c is at bits [c*COUNT_W +: COUNT_W]; accepted-pulse count

## Operation
Per-channel registers:
- a_r: previous sample of a.
- cnt: high-run length, CW bits.
- cnt update rule: on each posedge, if a is high, cnt <= min(cnt+1, MAX_W+1); otherwise cnt <= 0.
- Saturation: cnt holds at MAX_W+1, so it never wraps.
- cnt therefore equals the length of the run that ended when fall is asserted.

Per-channel outputs:
- rise = a & ~a_r.
- fall = ~a & a_r.
- len = fall ? cnt : 0. Saturated runs report MAX_W+1.
- detected = fall & (cnt >= MIN_W) & (cnt <= MAX_W).
- too_long = a & (cnt == MAX_W). It asserts exactly once per run, on the (MAX_W+1)-th high cycle.

Counter behaviour:
- count increments on each detected, saturating at 2^COUNT_W-1.
- clr sets count to 0.
- If clr and detected occur in the same cycle, count becomes 1.
- clr does not affect a_r or cnt.

Reset:
- a_r, cnt and count all reset to 0.
- While rst is high, every output is forced to 0.
- Reset acts as a preceding low: if a is high in the first cycle after rst deasserts, rise asserts and a new run starts at length 1.
- Reset in the middle of a run discards that run; no fall or detected is produced for it.

Channels are fully independent; simultaneous events on different channels have no interaction.

## Timing
- rise, fall, detected, too_long and len are combinational from the current a and the registered state, so they have zero-cycle latency relative to the sample.
- count is registered and shows the new value on the cycle after detected.
- A continuously high input produces no fall and no detected; it produces only a single too_long.
- Minimum gap between pulses: one low cycle. A pattern of 0101 yields two detections when MIN_W = 1.

## Configuration
- PULSE_WIDTH_DETECTOR_SYNC_EN defined:
  - A 2-flop synchroniser per channel is inserted in front of all logic, and the synchronised value replaces a everywhere.
  - All outputs lag the raw input by 2 cycles.
  - Synchroniser flops reset to 0.
- Macro undefined: a is used directly, with no extra flops and zero latency as specified above.

## Structure
- Package pulse_detect_pkg holds the CW width function (clog2 of MAX_W+2) and a saturating-increment function shared by cnt and count.
- Sub-module pulse_width_channel holds one channel: a_r, cnt, count and the output equations.
- The top level instantiates CHANNELS copies of pulse_width_channel in a generate loop and packs the results into the flat len and count buses.

## Test plan
All scenarios use the defaults (CHANNELS=4, MIN_W=1, MAX_W=4, COUNT_W=8) unless stated otherwise.
- Single pulse: a[0] = 0,1,0 gives rise in cycle 1, then fall, detected[0]=1 and len=1 in cycle 2, then count[0]=1 one cycle later.
- Long runs:
  - 4-cycle high gives detected with len=4.
  - 5-cycle high gives too_long on the 5th high cycle, then fall with len=5 and no detected.
  - 9-cycle high gives too_long exactly once and len=5.
- MIN_W=2, MAX_W=3: a 1-cycle pulse gives fall with len=1 and no detected; a 2-cycle pulse gives detected.
- Counter:
  - 3 pulses give count=3.
  - clr coincident with the 4th detected gives count=1.
  - 300 pulses saturate count at 255.
- Reset mid-run: a high for 2 cycles, rst for 1 cycle, a still high. During rst all outputs are 0. The first post-reset cycle gives rise. Dropping a after 3 more high cycles gives len=3 and detected.
- Independence: channels 0–3 driven with runs of 1, 4, 5 and constant-high simultaneously give detected=4'b0011, too_long on channel 2 at its 5th high cycle and on channel 3 at its 5th high cycle, and no cross-channel effects. With PULSE_WIDTH_DETECTOR_SYNC_EN defined, all responses shift by exactly 2 cycles.
